fft_ctrl_param: RTL

- Parametrised successor of the two-iteration in-place FFT controller.
- Sequences one frame through input load (INPT), iteration 1 (ITR1, IOBUF→FSC), iteration 2 (ITR2, FSC→IOBUF), output drain (OUPT), then a fixed stall.
- Drives bank-interleaved dual-port addresses, datapath selects, write enables and twiddle exponents; sits between the top-level handshake and the MDC/FSC/IOBUF datapath.
- Adds over the fixed 8-point version: configurable depth and latencies, ABORT, READY, a last-output pulse and back-to-back frame restart.

---
 rtl/fft_ctrl_pkg.sv | 52 +++++
 rtl/fft_lag_counter.sv | 29 ++
 rtl/fft_ctrl_param.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared state encodings and index/address helpers for the parametrised FFT controller.
// Address helpers work on AW_MAX-wide vectors; only the low aw bits are meaningful.
package fft_ctrl_pkg;

    localparam int unsigned AW_MAX = 10;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INPT = 3'd1;
    localparam logic [2:0] S_ITR1 = 3'd2;
    localparam logic [2:0] S_ITR2 = 3'd3;
    localparam logic [2:0] S_OUPT = 3'd4;
    localparam logic [2:0] S_STL  = 3'd5;

    typedef logic [AW_MAX-1:0] addr_t;

    function automatic logic bank_parity(input addr_t v);
        return ^v;
    endfunction

    // {m, v[0], v[aw-1:2]}
    function automatic addr_t map_itr1(input addr_t v, input logic m, input int unsigned aw);
        addr_t r;
        r = '0;
        for (int unsigned i = 0; i < AW_MAX - 2; i++) begin
            if (i + 2 < aw) r[i] = v[i+2];
        end
        r[aw-1] = m;
        r[aw-2] = v[0];
        return r;
    endfunction

    // {v[0], m, v[aw-1:2]}
    function automatic addr_t map_oupt(input addr_t v, input logic m, input int unsigned aw);
        addr_t r;
        r = '0;
        for (int unsigned i = 0; i < AW_MAX - 2; i++) begin
            if (i + 2 < aw) r[i] = v[i+2];
        end
        r[aw-1] = v[0];
        r[aw-2] = m;
        return r;
    endfunction

    // {v[aw-1:1], m}
    function automatic addr_t map_itr2(input addr_t v, input logic m);
        addr_t r;
        r    = v;
        r[0] = m;
        return r;
    endfunction

endpackage

// File: rtl/fft_lag_counter.sv
// Counter that trails a free-running count by LAT cycles while run is high.
// It idles at zero until the leading count reaches LAT, then advances every cycle.
module fft_lag_counter #(
    parameter int unsigned AW  = 3,
    parameter int unsigned LAT = 2
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          clr,
    input  logic          run,
    input  logic [AW-1:0] cnt,
    output logic [AW-1:0] lag_cnt
);

    localparam logic [AW-1:0] LAT_V = AW'(LAT);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            lag_cnt <= '0;
        end else if (clr || !run) begin
            lag_cnt <= '0;
        end else if (lag_cnt == '0 && cnt < LAT_V) begin
            lag_cnt <= '0;
        end else begin
            lag_cnt <= lag_cnt + AW'(1);
        end
    end

endmodule

// File: rtl/fft_ctrl_param.sv
// Two-iteration in-place FFT frame controller: load, ITR1, ITR2, drain, stall.
// Generates bank-interleaved addresses, datapath selects, write enables and twiddle exponents.
module fft_ctrl_param
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned AW      = 3,
    parameter int unsigned EW      = AW + 1,
    parameter int unsigned WB_LAT  = 2,
    parameter int unsigned EXP_LAT = 1,
    parameter int unsigned STL_CYC = 3
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          START,
    input  logic          ABORT,
    output logic          READY,
    output logic          DONE,
    output logic          LAST,
    output logic          SEL_EXTN,
    output logic          SEL_ITR,
    output logic          SEL_PERMW,
    output logic          SEL_PERMR,
    output logic          SEL_MDCFFT,
    output logic          WE_FSC,
    output logic          WE_IOBUF,
    output logic [AW-1:0] ADDR0_FSC,
    output logic [AW-1:0] ADDR1_FSC,
    output logic [AW-1:0] ADDR0_IOBUF,
    output logic [AW-1:0] ADDR1_IOBUF,
    output logic [EW-1:0] EXP0,
    output logic [EW-1:0] EXP1
);

    localparam int unsigned SW = (STL_CYC > 1) ? $clog2(STL_CYC) : 1;

    logic [2:0]    state, state_nxt;
    logic [AW-1:0] cnt, dnt, ent;
    logic [SW-1:0] stl_cnt;
    logic          bir, bi, biw;
    logic          active, in_itr, clr, stl_last;
    addr_t         c, d, io0, io1, fsc0, fsc1;
    logic [EW-1:0] n1, exp0;

    assign c        = addr_t'(cnt);
    assign d        = addr_t'(dnt);
    assign bi       = bank_parity(c);
    assign biw      = bank_parity(d);
    assign in_itr   = (state == S_ITR1) || (state == S_ITR2);
    assign active   = in_itr || (state == S_INPT) || (state == S_OUPT);
    assign stl_last = (stl_cnt == SW'(STL_CYC - 1));

    // Load/drain end on the read count; iterations end once write-back has caught up.
    assign clr = (((state == S_INPT) || (state == S_OUPT)) && (&cnt)) || (in_itr && (&dnt));

    always_comb begin
        state_nxt = state;
        if (ABORT) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (START) state_nxt = S_INPT;
                S_INPT:  if (clr) state_nxt = S_ITR1;
                S_ITR1:  if (clr) state_nxt = S_ITR2;
                S_ITR2:  if (clr) state_nxt = S_OUPT;
                S_OUPT:  if (clr) state_nxt = S_STL;
                S_STL:   if (stl_last) state_nxt = START ? S_INPT : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            stl_cnt <= '0;
            bir     <= 1'b0;
        end else begin
            state <= state_nxt;
            bir   <= bi;
            if (ABORT || clr || !active) cnt <= '0;
            else                         cnt <= cnt + AW'(1);
            if (ABORT || state != S_STL || stl_last) stl_cnt <= '0;
            else                                     stl_cnt <= stl_cnt + SW'(1);
        end
    end

    fft_lag_counter #(.AW(AW), .LAT(WB_LAT)) u_dnt (
        .CLK(CLK), .RSTn(RSTn), .clr(clr || ABORT), .run(in_itr), .cnt(cnt), .lag_cnt(dnt)
    );

    fft_lag_counter #(.AW(AW), .LAT(EXP_LAT)) u_ent (
        .CLK(CLK), .RSTn(RSTn), .clr(clr || ABORT), .run(in_itr), .cnt(cnt), .lag_cnt(ent)
    );

    always_comb begin
        io0  = '0;
        io1  = '0;
        fsc0 = '0;
        fsc1 = '0;
        case (state)
            S_INPT: begin
                io0 = c;
                io1 = c;
            end
            S_ITR1: begin
                io0  = map_itr1(c, bi, AW);
                io1  = map_itr1(c, ~bi, AW);
                fsc0 = map_itr1(d, biw, AW);
                fsc1 = map_itr1(d, ~biw, AW);
            end
            S_ITR2: begin
                fsc0 = map_itr2(c, bi);
                fsc1 = map_itr2(c, ~bi);
                io0  = map_itr2(d, biw);
                io1  = map_itr2(d, ~biw);
            end
            S_OUPT: begin
                io0 = map_oupt(c, bi, AW);
                io1 = map_oupt(c, ~bi, AW);
            end
            default: ;
        endcase
    end

    assign ADDR0_IOBUF = AW'(io0);
    assign ADDR1_IOBUF = AW'(io1);
    assign ADDR0_FSC   = AW'(fsc0);
    assign ADDR1_FSC   = AW'(fsc1);

    assign n1   = (state == S_ITR1) ? EW'(ent >> 1) : '0;
    assign exp0 = ent[0] ? n1 : '0;
    assign EXP0 = exp0;
    assign EXP1 = exp0 + (n1 << 1);

    assign READY      = (state == S_IDLE);
    assign DONE       = (state == S_OUPT);
    assign LAST       = (state == S_OUPT) && (&cnt);
    assign SEL_EXTN   = (state != S_INPT);
    assign SEL_ITR    = (state == S_ITR2);
    assign SEL_PERMW  = (state == S_INPT) ? bi : biw;
    assign SEL_PERMR  = bir;
    assign SEL_MDCFFT = in_itr && !cnt[0];
    assign WE_IOBUF   = (state == S_INPT) || (state == S_ITR2);
    assign WE_FSC     = (state == S_ITR1);

endmodule
